// File: rtl/lutnn_uart_host.sv
// Host-side requester for the LUTNN UART classification protocol.
// It sends one input vector as bytes, MSB byte first, then returns the single class byte as a result beat.
module lutnn_uart_host #(
    parameter int N_INPUTS       = 20,
    parameter int OUT_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] s_vec_data,
    input  logic                s_vec_valid,
    output logic                s_vec_ready,
    output logic [OUT_BITS-1:0] m_cls_data,
    output logic                m_cls_timeout,
    output logic                m_cls_proto_err,
    output logic                m_cls_valid,
    input  logic                m_cls_ready,
    output logic [7:0]          tx_tdata,
    output logic                tx_tvalid,
    input  logic                tx_tready,
    input  logic [7:0]          rx_tdata,
    input  logic                rx_tvalid,
    output logic                rx_tready,
    output logic                busy
);

    localparam int N_BYTES     = (N_INPUTS + 7) / 8;
    localparam int PADDED_BITS = 8 * N_BYTES;
    localparam int CNT_W       = $clog2(N_BYTES + 1);
    localparam int TO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = {TO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A response byte with any bit set above the class field is malformed.
    function automatic logic upper_bits_set(input logic [7:0] b);
        logic [7:0] mask;
        mask = 8'hFF << OUT_BITS;
        return |(b & mask);
    endfunction

    state_t                 r_state,         w_state_nxt;
    logic [PADDED_BITS-1:0] r_shreg,         w_shreg_nxt;
    logic [CNT_W-1:0]       r_byte_cnt,      w_byte_cnt_nxt;
    logic [TO_W-1:0]        r_to_cnt,        w_to_cnt_nxt;
    logic                   r_s_vec_ready,   w_s_vec_ready_nxt;
    logic                   r_tx_tvalid,     w_tx_tvalid_nxt;
    logic                   r_rx_tready,     w_rx_tready_nxt;
    logic [OUT_BITS-1:0]    r_cls_data,      w_cls_data_nxt;
    logic                   r_cls_timeout,   w_cls_timeout_nxt;
    logic                   r_cls_proto_err, w_cls_proto_err_nxt;
    logic                   r_cls_valid,     w_cls_valid_nxt;
    logic                   r_busy,          w_busy_nxt;

    // Next-state and next-output decode for the transaction sequencer.
    always_comb begin
        w_state_nxt         = r_state;
        w_shreg_nxt         = r_shreg;
        w_byte_cnt_nxt      = r_byte_cnt;
        w_to_cnt_nxt        = r_to_cnt;
        w_s_vec_ready_nxt   = r_s_vec_ready;
        w_tx_tvalid_nxt     = r_tx_tvalid;
        w_rx_tready_nxt     = r_rx_tready;
        w_cls_data_nxt      = r_cls_data;
        w_cls_timeout_nxt   = r_cls_timeout;
        w_cls_proto_err_nxt = r_cls_proto_err;
        w_cls_valid_nxt     = r_cls_valid;
        w_busy_nxt          = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (s_vec_valid) begin
                    w_shreg_nxt       = PADDED_BITS'(s_vec_data);
                    w_byte_cnt_nxt    = {CNT_W{1'b0}};
                    w_s_vec_ready_nxt = 1'b0;
                    w_tx_tvalid_nxt   = 1'b1;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = ST_SEND;
                end else begin
                    w_s_vec_ready_nxt = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_tx_tvalid && tx_tready) begin
                    w_shreg_nxt    = r_shreg << 8;
                    w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_tx_tvalid_nxt = 1'b0;
                        w_to_cnt_nxt    = {TO_W{1'b0}};
                        w_state_nxt     = ST_WAIT;
                    end else begin
                        w_tx_tvalid_nxt = 1'b1;
                    end
                end else begin
                    w_tx_tvalid_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_to_cnt != TO_MAX) begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end else begin
                    w_to_cnt_nxt = r_to_cnt;
                end
                // A response landing on the expiry cycle still counts as a response.
                if (rx_tvalid) begin
                    w_cls_data_nxt      = rx_tdata[OUT_BITS-1:0];
                    w_cls_proto_err_nxt = upper_bits_set(rx_tdata);
                    w_cls_timeout_nxt   = 1'b0;
                    w_cls_valid_nxt     = 1'b1;
                    w_rx_tready_nxt     = 1'b0;
                    w_state_nxt         = ST_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_cls_data_nxt      = {OUT_BITS{1'b0}};
                    w_cls_proto_err_nxt = 1'b0;
                    w_cls_timeout_nxt   = 1'b1;
                    w_cls_valid_nxt     = 1'b1;
                    w_rx_tready_nxt     = 1'b0;
                    w_state_nxt         = ST_DONE;
                end else begin
                    w_rx_tready_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (m_cls_ready) begin
                    w_cls_valid_nxt   = 1'b0;
                    w_s_vec_ready_nxt = 1'b1;
                    w_rx_tready_nxt   = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end else begin
                    w_cls_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_tx_tvalid_nxt   = 1'b0;
                w_cls_valid_nxt   = 1'b0;
                w_s_vec_ready_nxt = 1'b1;
                w_rx_tready_nxt   = 1'b1;
                w_busy_nxt        = 1'b0;
                w_state_nxt       = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_shreg         <= {PADDED_BITS{1'b0}};
            r_byte_cnt      <= {CNT_W{1'b0}};
            r_to_cnt        <= {TO_W{1'b0}};
            r_s_vec_ready   <= 1'b1;
            r_tx_tvalid     <= 1'b0;
            r_rx_tready     <= 1'b1;
            r_cls_data      <= {OUT_BITS{1'b0}};
            r_cls_timeout   <= 1'b0;
            r_cls_proto_err <= 1'b0;
            r_cls_valid     <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_shreg         <= w_shreg_nxt;
            r_byte_cnt      <= w_byte_cnt_nxt;
            r_to_cnt        <= w_to_cnt_nxt;
            r_s_vec_ready   <= w_s_vec_ready_nxt;
            r_tx_tvalid     <= w_tx_tvalid_nxt;
            r_rx_tready     <= w_rx_tready_nxt;
            r_cls_data      <= w_cls_data_nxt;
            r_cls_timeout   <= w_cls_timeout_nxt;
            r_cls_proto_err <= w_cls_proto_err_nxt;
            r_cls_valid     <= w_cls_valid_nxt;
            r_busy          <= w_busy_nxt;
        end
    end

    assign s_vec_ready     = r_s_vec_ready;
    assign tx_tdata        = r_shreg[PADDED_BITS-1 -: 8];
    assign tx_tvalid       = r_tx_tvalid;
    assign rx_tready       = r_rx_tready;
    assign m_cls_data      = r_cls_data;
    assign m_cls_timeout   = r_cls_timeout;
    assign m_cls_proto_err = r_cls_proto_err;
    assign m_cls_valid     = r_cls_valid;
    assign busy            = r_busy;

endmodule

// File: tb/tb_lutnn_uart_host.sv
// Directed bench for lutnn_uart_host: a byte/result model built from vector arithmetic,
// one negedge monitor comparing every handshake against it, plus literal pins.
module tb_lutnn_uart_host;

    localparam int NIN = 20;
    localparam int OB  = 4;
    localparam int TMO = 100;
    localparam int NB  = (NIN + 7) / 8;
    localparam logic [5:0] TMO_RES = 6'b0000_1_0;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NIN-1:0] s_vec_data;
    logic           s_vec_valid, s_vec_ready;
    logic [OB-1:0]  m_cls_data;
    logic           m_cls_timeout, m_cls_proto_err, m_cls_valid, m_cls_ready;
    logic [7:0]     tx_tdata, rx_tdata;
    logic           tx_tvalid, tx_tready, rx_tvalid, rx_tready, busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_tx[$];
    logic [5:0] exp_res[$];
    logic [7:0] tx_log[$];
    logic [5:0] res_log[$];

    int         last_tx_edge, last_rx_edge, acc_edge;
    logic       acc_pend = 1'b0, p_tx_stall = 1'b0, p_valid = 1'b0, p_res_hold = 1'b0;
    logic [7:0] p_tx_data;
    logic [5:0] p_res;

    lutnn_uart_host #(.N_INPUTS(NIN), .OUT_BITS(OB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_vec_data(s_vec_data), .s_vec_valid(s_vec_valid), .s_vec_ready(s_vec_ready),
        .m_cls_data(m_cls_data), .m_cls_timeout(m_cls_timeout), .m_cls_proto_err(m_cls_proto_err),
        .m_cls_valid(m_cls_valid), .m_cls_ready(m_cls_ready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] byte_of(input logic [NIN-1:0] v, input int k);
        int unsigned x;
        x = 32'(v);
        return 8'((x >> (8 * (NB - 1 - k))) % 256);
    endfunction

    function automatic logic [5:0] cls_model(input logic [7:0] b);
        int unsigned v, q, hi;
        v  = 32'(b);
        q  = v % (1 << OB);
        hi = v / (1 << OB);
        return {4'(q), 1'b0, (hi != 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle the outputs mean something, compare them with the model queues.
    always @(negedge clk) begin
        if (rst) begin
            acc_pend   <= 1'b0;
            p_tx_stall <= 1'b0;
            p_valid    <= 1'b0;
            p_res_hold <= 1'b0;
        end else begin
            if (acc_pend && cyc == acc_edge) begin
                check("accept_to_tvalid", {tx_tvalid, s_vec_ready, busy}, 3'b101);
                acc_pend <= 1'b0;
            end
            if (s_vec_valid && s_vec_ready) begin
                acc_edge <= cyc + 1;
                acc_pend <= 1'b1;
            end
            if (p_tx_stall) check("tx_hold", {tx_tvalid, tx_tdata}, {1'b1, p_tx_data});
            if (tx_tvalid && tx_tready) begin
                check("tx_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check("tx_byte", tx_tdata, exp_tx.pop_front());
                tx_log.push_back(tx_tdata);
                last_tx_edge <= cyc + 1;
            end
            p_tx_stall <= tx_tvalid && !tx_tready;
            p_tx_data  <= tx_tdata;
            if (rx_tvalid && rx_tready) last_rx_edge <= cyc + 1;
            if (m_cls_valid && !p_valid) begin
                check("cls_expected", exp_res.size() > 0, 1);
                if (exp_res.size() > 0) begin
                    if (exp_res[0][1]) check("timeout_latency", cyc - last_tx_edge, TMO);
                    else               check("rx_latency", cyc - last_rx_edge, 0);
                end
            end
            if (p_res_hold)
                check("cls_hold", {m_cls_valid, m_cls_data, m_cls_timeout, m_cls_proto_err}, {1'b1, p_res});
            if (m_cls_valid && m_cls_ready) begin
                check("cls_pending", exp_res.size() > 0, 1);
                if (exp_res.size() > 0)
                    check("cls_result", {m_cls_data, m_cls_timeout, m_cls_proto_err}, exp_res.pop_front());
                res_log.push_back({m_cls_data, m_cls_timeout, m_cls_proto_err});
            end
            p_valid    <= m_cls_valid;
            p_res_hold <= m_cls_valid && !m_cls_ready;
            p_res      <= {m_cls_data, m_cls_timeout, m_cls_proto_err};
        end
    end

    task automatic offer(input logic [NIN-1:0] v);
        int n;
        s_vec_data  = v;
        s_vec_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_vec_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", n < 50, 1);
        @(posedge clk);
        #1;
        s_vec_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [NIN-1:0] v, input bit bp, input bit stale);
        int n;
        for (int k = 0; k < NB; k++) exp_tx.push_back(byte_of(v, k));
        tx_tready = !bp;
        offer(v);
        if (bp) begin
            for (int k = 0; k < NB; k++) begin
                n = 0;
                while (!tx_tvalid && n < 50) begin
                    tick();
                    n++;
                end
                check("tx_valid_bound", n < 50, 1);
                if (stale && k == 0) begin
                    rx_tdata  = 8'h55;
                    rx_tvalid = 1'b1;
                    tick();
                    rx_tvalid = 1'b0;
                    repeat (4) tick();
                end else begin
                    repeat (5) tick();
                end
                tx_tready = 1'b1;
                tick();
                tx_tready = 1'b0;
            end
            tx_tready = 1'b1;
        end else begin
            n = 0;
            while (exp_tx.size() != 0 && n < 50) begin
                tick();
                n++;
            end
            check("tx_drain_bound", n < 50, 1);
        end
    endtask

    task automatic respond(input logic [7:0] b);
        exp_res.push_back(cls_model(b));
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        tick();
        rx_tvalid = 1'b0;
    endtask

    task automatic collect(input int d);
        int n;
        n = 0;
        while (!m_cls_valid && n < 300) begin
            tick();
            n++;
        end
        check("cls_valid_bound", n < 300, 1);
        repeat (d) tick();
        m_cls_ready = 1'b1;
        tick();
        m_cls_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s_vec_data  = '0;
        s_vec_valid = 1'b0;
        m_cls_ready = 1'b0;
        tx_tready   = 1'b1;
        rx_tdata    = 8'h00;
        rx_tvalid   = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready", {s_vec_ready, rx_tready}, 2'b11);
        check("rst_tx", {tx_tvalid, tx_tdata}, 9'h000);
        check("rst_cls", {m_cls_valid, m_cls_data, m_cls_timeout, m_cls_proto_err}, 7'h00);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Basic frame, unthrottled.
        tx_log.delete(); res_log.delete();
        send_vec(20'hABCDE, 1'b0, 1'b0);
        check("basic_nbytes", tx_log.size(), 3);
        check("basic_b0", tx_log[0], 8'h0A);
        check("basic_b1", tx_log[1], 8'hBC);
        check("basic_b2", tx_log[2], 8'hDE);
        respond(8'h07);
        collect(0);
        check("basic_cls", res_log[0], 6'b0111_0_0);

        // Backpressure on every byte and on the result.
        send_vec(20'h5A3C1, 1'b1, 1'b0);
        respond(8'h0B);
        collect(10);

        // Timeout, then a late byte drained in IDLE.
        res_log.delete();
        send_vec(20'h0F0F0, 1'b0, 1'b0);
        exp_res.push_back(TMO_RES);
        collect(0);
        check("timeout_cls", res_log[0], 6'b0000_1_0);
        check("idle_rx_ready", rx_tready, 1);
        rx_tdata  = 8'h09;
        rx_tvalid = 1'b1;
        tick();
        rx_tvalid = 1'b0;
        repeat (20) tick();
        check("late_no_result", {m_cls_valid, busy}, 2'b00);

        // Protocol error.
        res_log.delete();
        send_vec(20'h13579, 1'b0, 1'b0);
        respond(8'h93);
        collect(3);
        check("proto_cls", res_log[0], 6'b0011_0_1);

        // Stale byte during SEND is dropped.
        res_log.delete();
        send_vec(20'hFEDCB, 1'b1, 1'b1);
        respond(8'h02);
        collect(0);
        check("stale_cls", res_log[0], 6'b0010_0_0);
        check("stale_one_result", res_log.size(), 1);

        // Reset after the second byte of a frame.
        tx_log.delete();
        for (int k = 0; k < NB; k++) exp_tx.push_back(byte_of(20'h12345, k));
        tx_tready = 1'b0;
        offer(20'h12345);
        tx_tready = 1'b1;
        tick();
        tick();
        tx_tready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_tx", tx_tvalid, 0);
        check("midrst_ready", {s_vec_ready, rx_tready, busy, m_cls_valid}, 4'b1100);
        check("midrst_two_bytes", tx_log.size(), 2);
        exp_tx.delete();
        repeat (2) tick();
        rst = 1'b0;
        tx_tready = 1'b1;
        tick();
        tx_log.delete(); res_log.delete();
        send_vec(20'h00001, 1'b0, 1'b0);
        check("after_rst_nbytes", tx_log.size(), 3);
        check("after_rst_b0", tx_log[0], 8'h00);
        check("after_rst_b1", tx_log[1], 8'h00);
        check("after_rst_b2", tx_log[2], 8'h01);
        respond(8'h0C);
        collect(1);
        check("after_rst_cls", res_log[0], 6'b1100_0_0);

        repeat (3) tick();
        check("tx_queue_empty", exp_tx.size(), 0);
        check("res_queue_empty", exp_res.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lutnn_uart_host.md
Name: lutnn_uart_host

Overview:
Host-side initiator for the LUTNN UART classification protocol; the requester end facing the on-board LUTNN UART endpoint.
- Takes one input vector over a valid/ready port and serializes it into N_BYTES bytes, MSB byte first, on a byte-stream TX port (feeds a uart_tx).
- Waits for the single class byte on a byte-stream RX port (fed by a uart_rx) and returns it as a result beat.
- Used in loopback self-test builds and a second-board test harness.

Parameters:
N_INPUTS, 20, input vector width in bits (matches NET_INPUTS of the target)
OUT_BITS, 4, class index width in bits (matches NET_OUTPUT_BITS; must be 1..8)
TIMEOUT_CYCLES, 2000000, clk cycles to wait for the response byte before aborting
Derived: N_BYTES = ceil(N_INPUTS/8); PADDED_BITS = 8*N_BYTES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s_vec_data  in  N_INPUTS  input vector to classify
s_vec_valid  in  1  vector valid
s_vec_ready  out  1  vector accepted when valid&&ready
m_cls_data  out  OUT_BITS  returned class index
m_cls_timeout  out  1  result is a timeout (class data = 0)
m_cls_proto_err  out  1  response byte had nonzero bits above OUT_BITS
m_cls_valid  out  1  result valid
m_cls_ready  in  1  result consumed when valid&&ready
tx_tdata  out  8  byte to UART transmitter
tx_tvalid  out  1  byte valid
tx_tready  in  1  transmitter accepts byte
rx_tdata  in  8  byte from UART receiver
rx_tvalid  in  1  received byte valid
rx_tready  out  1  byte consumed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-high; all outputs are registered.
  - Reset values: s_vec_ready=1, rx_tready=1, all other outputs 0; state=IDLE; counters 0.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - s_vec_ready=1.
  - On s_vec_valid: latch padded = {zeros, s_vec_data} into a PADDED_BITS shift register, clear byte_cnt, go to SEND. s_vec_ready drops the next cycle.
- SEND:
  - tx_tdata = shreg[PADDED_BITS-1 -: 8], so byte k = padded[PADDED_BITS-1-8k -: 8].
  - tx_tvalid is held high and tx_tdata held stable until tx_tready.
  - On each handshake: shift shreg left by 8 and increment byte_cnt.
  - Bytes go back-to-back; the next byte is presented the cycle after a handshake.
  - When the handshake completes byte N_BYTES-1: drop tx_tvalid, clear the timeout counter, go to WAIT.
- Stale RX bytes: in IDLE and SEND, rx_tready=1 and any received byte is discarded. This drains stale or late responses.
- WAIT:
  - rx_tready=1; the timeout counter increments every cycle.
  - First rx beat: m_cls_data = rx_tdata[OUT_BITS-1:0]; m_cls_proto_err = |rx_tdata[7:OUT_BITS] (0 when OUT_BITS=8); m_cls_timeout=0; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no rx beat: m_cls_data=0, m_cls_timeout=1, m_cls_proto_err=0; go to DONE.
  - If an rx beat and expiry occur in the same cycle, the rx beat wins.
- DONE:
  - m_cls_valid=1 and rx_tready=0; outputs are held stable until m_cls_ready.
  - On handshake: drop m_cls_valid, go to IDLE. s_vec_ready rises the following cycle.
- Latency: from vector accept to first tx_tvalid is 1 cycle. From the response rx beat to m_cls_valid is 1 cycle.
- Only one transaction is in flight at a time. A new vector is never accepted before the result is consumed.
- Reset asserted mid-SEND or mid-WAIT aborts immediately: tx_tvalid=0, partial frame abandoned, no result produced.
- Counter widths:
  - byte_cnt is $clog2(N_BYTES+1) bits.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits; it saturates and never wraps.

Test Plan:
- Basic frame (tx_tready=1, N_INPUTS=20): vector 20'hABCDE → tx bytes 0x0A, 0xBC, 0xDE in order. Then rx byte 0x07 → m_cls_data=4'h7, timeout=0, proto_err=0, one beat.
- Backpressure: hold tx_tready=0 for 5 cycles on each byte → tx_tdata stable while tx_tvalid=1, no byte duplicated or dropped. Hold m_cls_ready=0 for 10 cycles → result held constant.
- Timeout (TIMEOUT_CYCLES=100): send vector, never respond → m_cls_valid with timeout=1 and data=0 exactly 100 cycles after the last tx handshake. A later rx byte arriving in IDLE is drained and produces no result.
- Protocol error: response byte 0x93 → m_cls_data=4'h3, proto_err=1.
- Stale-byte drain: inject rx byte 0x55 during SEND → discarded. The subsequent real response 0x02 yields class 2.
- Mid-frame reset: assert rst after the second tx byte → all outputs at reset values immediately (asynchronous). The next vector 20'h00001 transmits 0x00, 0x00, 0x01 from byte 0.
